// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
// Holds the FSM state encoding, default widths and the ALU opcode names.
package alu_seq_pkg;

   localparam int SEQ_WIDTH = 16;
   localparam int SEQ_OPW   = 3;
   localparam int SEQ_CNTW  = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESP   = 2'd2
   } seq_state_t;

   localparam logic [SEQ_OPW-1:0] OP0 = 3'b000;
   localparam logic [SEQ_OPW-1:0] OP1 = 3'b001;
   localparam logic [SEQ_OPW-1:0] OP2 = 3'b010;
   localparam logic [SEQ_OPW-1:0] OP3 = 3'b011;
   localparam logic [SEQ_OPW-1:0] OP4 = 3'b100;

endpackage

// File: rtl/alu_op_sequencer.sv
// Synthesizable front end for the 16-bit ALU: accepts a request, holds operands
// for SETTLE cycles, captures acc and returns it over a valid/ready handshake.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | ready for a request; alu_* keep the previous operation
// ST_SETTLE | operands held on the ALU, settle counter running down
// ST_RESP   | captured result presented, waiting for rsp_ready
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH  = SEQ_WIDTH,
   parameter int OPW    = SEQ_OPW,
   parameter int SETTLE = 2,
   parameter int CNTW   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [OPW-1:0]   req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic             req_cin,
   input  logic             req_chain,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_cin,
   output logic [OPW-1:0]   alu_s0,
   input  logic [WIDTH-1:0] alu_acc,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic [OPW-1:0]   rsp_op,
   output logic             busy,
   output logic [CNTW-1:0]  op_count
);

   // Terminal count is zero, so the load value is SETTLE-1 (SETTLE limited to 1..15).
   localparam logic [SEQ_CNTW-1:0] CNT_LOAD = SEQ_CNTW'(SETTLE - 1);

   seq_state_t           state_q;
   seq_state_t           state_d;
   logic [SEQ_CNTW-1:0]  cnt_q;
   logic [WIDTH-1:0]     last_result_q;
   logic                 accept;
   logic                 capture;
   logic                 retire;

   assign req_ready = (state_q == ST_IDLE) && !reset;
   assign busy      = (state_q != ST_IDLE);

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      capture = 1'b0;
      retire  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready) begin
               accept  = 1'b1;
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == '0) begin
               capture = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               retire  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q <= CNT_LOAD;
      end else if (state_q == ST_SETTLE && cnt_q != '0) begin
         cnt_q <= cnt_q - SEQ_CNTW'(1);
      end
   end

   // Operand registers change only on acceptance so the ALU sees stable inputs otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_a   <= '0;
         alu_b   <= '0;
         alu_cin <= 1'b0;
         alu_s0  <= '0;
      end else if (accept) begin
         alu_a   <= req_chain ? last_result_q : req_a;
         alu_b   <= req_b;
         alu_cin <= req_cin;
         alu_s0  <= req_op;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid     <= 1'b0;
         rsp_data      <= '0;
         rsp_op        <= '0;
         last_result_q <= '0;
      end else if (capture) begin
         rsp_valid     <= 1'b1;
         rsp_data      <= alu_acc;
         rsp_op        <= alu_s0;
         last_result_q <= alu_acc;
      end else if (retire) begin
         rsp_valid     <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_count <= '0;
      end else if (retire) begin
         op_count <= op_count + CNTW'(1);
      end
   end

endmodule
